// File: rtl/vco_voice_sched.sv
// vco_voice_sched: four-voice wavetable VCO scheduler sharing one LUT port and one wavetable port
module vco_voice_sched #(
  parameter int W         = 16,
  parameter int LUT_AW    = 9,
  parameter int WT_AW     = 8,
  parameter int BIT_START = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [3:0]          phase_rst,
  output logic                lut_re,
  output logic [LUT_AW-1:0]   lut_addr,
  input  logic [W-1:0]        lut_data,
  output logic                wt_re,
  output logic [WT_AW-1:0]    wt_addr,
  input  logic [W-1:0]        wt_data,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);
  typedef enum logic [2:0] {IDLE, LUT, ACC, CAP, COMMIT} state_t;
  state_t state, state_nx;
  logic [1:0] v;
  logic signed [W-1:0] in_reg [4];
  logic [3:0] prst_reg;
  logic [31:0] phase [4];
  logic [W-1:0] shadow [4];
  logic signed [W-1:0] sh;
  logic [31:0] next_ph;
  always_comb begin
    sh = in_reg[v] >>> 6;
    next_ph = (prst_reg[v] ? 32'd0 : phase[v]) + 32'(lut_data);
    lut_addr = sh[W-1] ? '0 : LUT_AW'(sh);
    wt_addr = next_ph[BIT_START+WT_AW-1:BIT_START];
  end
  always_comb begin
    state_nx = state == IDLE ? (sample_strobe ? LUT : IDLE) :
               state == LUT  ? ACC :
               state == ACC  ? CAP :
               state == CAP  ? (v == 2'd3 ? COMMIT : LUT) : IDLE;
  end
  always_comb begin
    lut_re = state == LUT;
    wt_re = state == ACC;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      v <= '0;
      prst_reg <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
      for (int i = 0; i < 4; i++) begin
        in_reg[i] <= '0;
        phase[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state <= state_nx;
      sample_valid <= state == COMMIT;
      overrun <= sample_strobe && state != IDLE;
      if (state == IDLE && sample_strobe) begin
        in_reg[0] <= sample_in0;
        in_reg[1] <= sample_in1;
        in_reg[2] <= sample_in2;
        in_reg[3] <= sample_in3;
        prst_reg <= phase_rst;
        v <= '0;
      end
      if (state == ACC) phase[v] <= next_ph;
      if (state == CAP) begin
        shadow[v] <= wt_data;
        v <= v + 2'd1;
      end
      if (state == COMMIT) begin
        sample_out0 <= shadow[0];
        sample_out1 <= shadow[1];
        sample_out2 <= shadow[2];
        sample_out3 <= shadow[3];
      end
    end
  end
endmodule

// File: tb/tb_vco_voice_sched.sv
// tb_vco_voice_sched: directed and randomized frames checked against a per-frame reference model
module tb_vco_voice_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_strobe = 1'b0;
  logic [15:0] sin0 = '0, sin1 = '0, sin2 = '0, sin3 = '0;
  logic [3:0] phase_rst = '0;
  logic lut_re, wt_re, sample_valid, busy, overrun;
  logic [8:0] lut_addr;
  logic [7:0] wt_addr;
  logic [15:0] lut_data = '0, wt_data = '0;
  logic [15:0] so0, so1, so2, so3;
  logic [15:0] lut_mem [512];
  logic [15:0] wt_mem [256];
  logic [31:0] ph [4];
  logic [15:0] prev_out [4];
  int cap_la [4];
  int cap_wa [4];
  int n_cmp = 0;
  int n_err = 0;

  vco_voice_sched dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .sample_in0(sin0), .sample_in1(sin1), .sample_in2(sin2), .sample_in3(sin3),
    .phase_rst(phase_rst), .lut_re(lut_re), .lut_addr(lut_addr), .lut_data(lut_data),
    .wt_re(wt_re), .wt_addr(wt_addr), .wt_data(wt_data),
    .sample_out0(so0), .sample_out1(so1), .sample_out2(so2), .sample_out3(so3),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lut_re) lut_data <= lut_mem[lut_addr];
    if (wt_re) wt_data <= wt_mem[wt_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, "_out0"}, {16'd0, so0}, {16'd0, e0});
    chk({tag, "_out1"}, {16'd0, so1}, {16'd0, e1});
    chk({tag, "_out2"}, {16'd0, so2}, {16'd0, e2});
    chk({tag, "_out3"}, {16'd0, so3}, {16'd0, e3});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      ph[i] = '0;
      prev_out[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_valid", {31'd0, sample_valid}, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);
  endtask

  // Strobe now (cycle t), then check every cycle t+1..t+14; extra>0 adds a stray strobe at t+extra.
  task automatic frame(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                       input logic [15:0] i3, input logic [3:0] pr, input int extra);
    logic [15:0] ins [4];
    int exp_la [4];
    int exp_wa [4];
    logic [15:0] eo [4];
    ins[0] = i0; ins[1] = i1; ins[2] = i2; ins[3] = i3;
    for (int k = 0; k < 4; k++) begin
      int x;
      x = int'($signed(ins[k]));
      exp_la[k] = x < 0 ? 0 : x / 64;
      ph[k] = (pr[k] ? 32'd0 : ph[k]) + {16'd0, lut_mem[exp_la[k]]};
      exp_wa[k] = int'(ph[k][17:10]);
      eo[k] = wt_mem[exp_wa[k]];
    end
    sin0 = i0; sin1 = i1; sin2 = i2; sin3 = i3;
    phase_rst = pr;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    sin0 = 16'($urandom); sin1 = 16'($urandom); sin2 = 16'($urandom); sin3 = 16'($urandom);
    phase_rst = 4'($urandom);
    for (int c = 1; c <= 14; c++) begin
      bit lr, wr;
      lr = (c % 3 == 1) && c <= 10;
      wr = (c % 3 == 2) && c <= 11;
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 13});
      chk($sformatf("valid_c%0d", c), {31'd0, sample_valid}, {31'd0, c == 14});
      chk($sformatf("overrun_c%0d", c), {31'd0, overrun}, {31'd0, extra > 0 && c == extra + 1});
      chk($sformatf("lut_re_c%0d", c), {31'd0, lut_re}, {31'd0, lr});
      chk($sformatf("wt_re_c%0d", c), {31'd0, wt_re}, {31'd0, wr});
      if (lr) begin
        cap_la[(c - 1) / 3] = int'(lut_addr);
        chk($sformatf("lut_addr_v%0d", (c - 1) / 3), {23'd0, lut_addr}, exp_la[(c - 1) / 3]);
      end
      if (wr) begin
        cap_wa[(c - 2) / 3] = int'(wt_addr);
        chk($sformatf("wt_addr_v%0d", (c - 2) / 3), {24'd0, wt_addr}, exp_wa[(c - 2) / 3]);
      end
      if (c == 14) chk_outs("commit", eo[0], eo[1], eo[2], eo[3]);
      else if (c % 4 == 0) chk_outs("hold", prev_out[0], prev_out[1], prev_out[2], prev_out[3]);
      if (c == extra) sample_strobe = 1'b1;
      if (c < 14) begin
        tick();
        sample_strobe = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) prev_out[k] = eo[k];
  endtask

  initial begin
    for (int i = 0; i < 512; i++) lut_mem[i] = 16'h0400;
    for (int i = 0; i < 256; i++) wt_mem[i] = 16'($urandom);
    model_clear();
    // reset held with strobes toggling
    for (int i = 0; i < 4; i++) begin
      sample_strobe = ~sample_strobe;
      sin0 = 16'h1234;
      tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_valid", {31'd0, sample_valid}, 0);
      chk("rst_lut_re", {31'd0, lut_re}, 0);
      chk("rst_wt_re", {31'd0, wt_re}, 0);
      chk_outs("rst", 16'd0, 16'd0, 16'd0, 16'd0);
    end
    sample_strobe = 1'b0;
    rst_n = 1'b1;
    idle(2);
    // address sequence
    frame(16'h0C00, 16'h0000, 16'h1000, 16'h0040, 4'b0000, 0);
    chk("seq_la0", cap_la[0], 48);
    chk("seq_la1", cap_la[1], 0);
    chk("seq_la2", cap_la[2], 64);
    chk("seq_la3", cap_la[3], 1);
    for (int k = 0; k < 4; k++) chk($sformatf("seq_wa%0d", k), cap_wa[k], 1);
    chk_outs("seq_wt1", wt_mem[1], wt_mem[1], wt_mem[1], wt_mem[1]);
    idle(3);
    // clamp
    frame(16'h8000, 16'hFFFF, 16'h003F, 16'h7FC0, 4'b0000, 0);
    chk("clamp_neg", cap_la[0], 0);
    chk("clamp_m1", cap_la[1], 0);
    frame(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);
    chk("clamp_pos", cap_la[0], 511);
    idle(1);
    // overrun at t+5, then a strobe landing on the sample_valid cycle
    frame(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'b0000, 5);
    frame(16'h0500, 16'h0600, 16'h0700, 16'h0800, 4'b0000, 13);
    frame(16'h0900, 16'h0A00, 16'h0B00, 16'h0C00, 4'b0000, 0);
    idle(2);
    // mid-frame asynchronous reset
    sin0 = 16'h0C00; sin1 = 16'h0C00; sin2 = 16'h0C00; sin3 = 16'h0C00;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, sample_valid}, 0);
    chk("mid_rst_lut_re", {31'd0, lut_re}, 0);
    chk("mid_rst_wt_re", {31'd0, wt_re}, 0);
    chk_outs("mid_rst", 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(16);
    chk_outs("post_rst", 16'd0, 16'd0, 16'd0, 16'd0);
    frame(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 4'b0000, 0);
    chk("post_rst_wa0", cap_wa[0], 1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      frame(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 4'b0000, 0);
    end
    idle(1);
    frame(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 4'b0001, 0);
    chk("sync_v0", cap_wa[0], 1);
    chk("sync_v1", cap_wa[1], 6);
    idle(1);
    frame(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 4'b0000, 0);
    chk("sync_once_v0", cap_wa[0], 2);
    // phase wrap over 257 frames spaced 20 cycles
    do_reset();
    for (int k = 0; k < 257; k++) begin
      frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000, 0);
      chk($sformatf("wrap_k%0d", k), cap_wa[0], (k + 1) % 256);
      idle(6);
    end
    // randomized memories, inputs, syncs and stray strobes
    for (int i = 0; i < 512; i++) lut_mem[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) wt_mem[i] = 16'($urandom);
    for (int k = 0; k < 40; k++) begin
      int ex;
      ex = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 13)) : 0;
      frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), ex);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
